switch_conditioner: RTL

Input stage between the raw Zybo slide switches and the jackpot win-check logic. It synchronises each switch to CLOCK, debounces it against a prescaled sample tick, and presents clean levels plus one-cycle rise/fall pulses. A valid/ack event port carries switch-change snapshots, so the game logic compares against stable values instead of raw pins.

---
 rtl/switch_conditioner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/switch_conditioner.sv
// Purpose: synchronise, debounce and edge-detect raw slide switches; publish change snapshots on a valid/ack port.
// Latency: 2 sync cycles + DEBOUNCE_TICKS sample ticks to SW_STABLE; pulses coincide with SW_STABLE; EVT_VALID one cycle later.
// Backpressure: none on the switch path; an unacked event is overwritten by the newest snapshot and EVT_OVERRUN latches.
module switch_conditioner #(
   parameter int N_SW           = 4,
   parameter int TICK_DIV       = 125000,
   parameter int DEBOUNCE_TICKS = 10
) (
   input  logic            CLOCK,
   input  logic            RESET,
   input  logic [N_SW-1:0] SWITCHES,
   output logic [N_SW-1:0] SW_STABLE,
   output logic [N_SW-1:0] SW_RISE,
   output logic [N_SW-1:0] SW_FALL,
   output logic            EVT_VALID,
   output logic [N_SW-1:0] EVT_DATA,
   input  logic            EVT_ACK,
   output logic            EVT_OVERRUN
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);

   // two-flop synchroniser chain
   logic [N_SW-1:0] meta_d, meta_q;
   logic [N_SW-1:0] sync_d, sync_q;

   // shared sample-tick prescaler
   logic [TW-1:0]   tick_cnt_d, tick_cnt_q;
   logic            tick;

   // per-bit debounce state
   logic [N_SW-1:0][CW-1:0] cnt_d, cnt_q;
   logic [N_SW-1:0]         stable_d, stable_q;

   // registered edge pulses, aligned with the cycle SW_STABLE changes
   logic [N_SW-1:0] rise_d, rise_q;
   logic [N_SW-1:0] fall_d, fall_q;
   logic            chg;

   // event channel state
   logic            evt_vld_d, evt_vld_q;
   logic [N_SW-1:0] evt_dat_d, evt_dat_q;
   logic            evt_ovr_d, evt_ovr_q;

   // synchroniser next state: raw pins enter the first stage, first stage feeds the second
   always_comb begin
      meta_d = SWITCHES;
      sync_d = meta_q;
   end

   // prescaler: free-running count 0..TICK_DIV-1, tick on the terminal count
   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // debounce: any agreement clears the count; a disagreement must survive DEBOUNCE_TICKS ticks to be accepted
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < N_SW; i++) begin
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] >= CNT_LAST) begin
               stable_d[i] = sync_q[i];
               cnt_d[i]    = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // edge pulses registered alongside stable_q so they appear in the same cycle as the new level
   always_comb begin
      rise_d = stable_d & ~stable_q;
      fall_d = ~stable_d & stable_q;
   end

   // event channel: a change loads a snapshot; an unacked pending event gets overwritten and flags overrun
   always_comb begin
      chg       = |(rise_q | fall_q);
      evt_vld_d = evt_vld_q;
      evt_dat_d = evt_dat_q;
      evt_ovr_d = evt_ovr_q;
      if (chg) begin
         evt_vld_d = 1'b1;
         evt_dat_d = stable_q;
         if (evt_vld_q && !EVT_ACK) begin
            evt_ovr_d = 1'b1;
         end
      end else if (evt_vld_q && EVT_ACK) begin
         evt_vld_d = 1'b0;
         evt_ovr_d = 1'b0;
      end
   end

   // state registers, all cleared by the asynchronous active-low reset
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         meta_q     <= '0;
         sync_q     <= '0;
         tick_cnt_q <= '0;
         cnt_q      <= '0;
         stable_q   <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
         evt_vld_q  <= 1'b0;
         evt_dat_q  <= '0;
         evt_ovr_q  <= 1'b0;
      end else begin
         meta_q     <= meta_d;
         sync_q     <= sync_d;
         tick_cnt_q <= tick_cnt_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         evt_vld_q  <= evt_vld_d;
         evt_dat_q  <= evt_dat_d;
         evt_ovr_q  <= evt_ovr_d;
      end
   end

   assign SW_STABLE   = stable_q;
   assign SW_RISE     = rise_q;
   assign SW_FALL     = fall_q;
   assign EVT_VALID   = evt_vld_q;
   assign EVT_DATA    = evt_dat_q;
   assign EVT_OVERRUN = evt_ovr_q;

endmodule
